// File: rtl/rc_pkg.sv
// rtl/rc_pkg.sv - shared RC channel constants, decoder FSM encoding and offset arithmetic
package rc_pkg;

  localparam int RC_CH_THROTTLE = 0;
  localparam int RC_CH_ROLL     = 1;
  localparam int RC_CH_PITCH    = 2;
  localparam int RC_CH_YAW      = 3;
  localparam int RC_NUM_CH      = 4;

  localparam int RC_OFFSET_W  = 11;
  localparam int RC_CENTER_US = 1500;
  localparam int RC_LOW_US    = 1000;
  localparam int RC_SPAN_US   = 500;

  localparam int RC_IV_W = 13;
  // Validated channel widths never exceed 2100, so 12 bits hold them.
  localparam int RC_W_W  = 12;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CH     = 2'd1,
    ST_COMMIT = 2'd2,
    ST_SKIP   = 2'd3
  } rc_state_e;

  function automatic logic [RC_OFFSET_W-1:0] rc_throttle(input logic [RC_W_W-1:0] w);
    if (w <= RC_W_W'(RC_LOW_US)) return '0;
    else if (w >= RC_W_W'(RC_LOW_US + 2 * RC_SPAN_US)) return RC_OFFSET_W'(2 * RC_SPAN_US);
    else return RC_OFFSET_W'(w - RC_W_W'(RC_LOW_US));
  endfunction

  // Two's-complement result; the mid-range subtraction wraps correctly in 11 bits.
  function automatic logic [RC_OFFSET_W-1:0] rc_center(input logic [RC_W_W-1:0] w);
    if (w <= RC_W_W'(RC_CENTER_US - RC_SPAN_US)) return RC_OFFSET_W'(-RC_SPAN_US);
    else if (w >= RC_W_W'(RC_CENTER_US + RC_SPAN_US)) return RC_OFFSET_W'(RC_SPAN_US);
    else return RC_OFFSET_W'(w) - RC_OFFSET_W'(RC_CENTER_US);
  endfunction

endpackage

// File: rtl/rc_us_tick_gen.sv
// rtl/rc_us_tick_gen.sv - free-running prescaler emitting a one-cycle 1 us tick enable
module rc_us_tick_gen #(
  parameter int unsigned DIV = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rc_ppm_decoder.sv
// rtl/rc_ppm_decoder.sv - PPM frame decoder with validation and failsafe
// Optional centre deadband on pitch/roll/yaw: define RC_PPM_DEADBAND_EN.
module rc_ppm_decoder
  import rc_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned SYNC_MIN_US  = 3000,
  parameter int unsigned PULSE_MIN_US = 900,
  parameter int unsigned PULSE_MAX_US = 2100,
  parameter int unsigned FAILSAFE_MS  = 100
`ifdef RC_PPM_DEADBAND_EN
  , parameter int unsigned DEADBAND_US = 20
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ppm_in,
  output logic [RC_OFFSET_W-1:0] throttle_offset,
  output logic [RC_OFFSET_W-1:0] pitch_offset,
  output logic [RC_OFFSET_W-1:0] roll_offset,
  output logic [RC_OFFSET_W-1:0] yaw_offset,
  output logic                   frame_valid,
  output logic                   signal_lost
);

  localparam int unsigned MS_W = $clog2(FAILSAFE_MS + 1);

  logic ppm_s1_q, ppm_s2_q, ppm_s3_q;
  logic tick, rise, is_sync, is_chan;

  rc_state_e         state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [RC_IV_W-1:0] iv_q, iv_d;
  logic [RC_W_W-1:0] shadow_q [RC_NUM_CH];
  logic [RC_W_W-1:0] shadow_d [RC_NUM_CH];
  logic [9:0]        us_q, us_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic [RC_OFFSET_W-1:0] thr_q, thr_d, pit_q, pit_d, rol_q, rol_d, yaw_q, yaw_d;
  logic fv_q, fv_d, lost_q, lost_d;

`ifdef RC_PPM_DEADBAND_EN
  function automatic logic [RC_OFFSET_W-1:0] axis_offset(input logic [RC_W_W-1:0] w);
    if (w >= RC_W_W'(RC_CENTER_US - DEADBAND_US) && w <= RC_W_W'(RC_CENTER_US + DEADBAND_US))
      return '0;
    return rc_center(w);
  endfunction
`else
  function automatic logic [RC_OFFSET_W-1:0] axis_offset(input logic [RC_W_W-1:0] w);
    return rc_center(w);
  endfunction
`endif

  rc_us_tick_gen #(.DIV(CLK_HZ / 1_000_000)) u_tick (
    .clk_i (clk),
    .rst_i (rst),
    .tick_o(tick)
  );

  assign rise    = ppm_s2_q & ~ppm_s3_q;
  assign is_sync = (iv_q >= RC_IV_W'(SYNC_MIN_US));
  assign is_chan = (iv_q >= RC_IV_W'(PULSE_MIN_US)) && (iv_q <= RC_IV_W'(PULSE_MAX_US));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    iv_d     = iv_q;
    us_d     = us_q;
    ms_d     = ms_q;
    thr_d    = thr_q;
    pit_d    = pit_q;
    rol_d    = rol_q;
    yaw_d    = yaw_q;
    fv_d     = 1'b0;
    lost_d   = lost_q;

    // The tick coinciding with an edge belongs to the interval that edge opens.
    if (rise) iv_d = tick ? RC_IV_W'(1) : '0;
    else if (tick && iv_q != '1) iv_d = iv_q + 1'b1;

    if (tick && ms_q != MS_W'(FAILSAFE_MS)) begin
      if (us_q == 10'd999) begin
        us_d = '0;
        ms_d = ms_q + 1'b1;
        if (ms_q == MS_W'(FAILSAFE_MS - 1)) begin
          lost_d = 1'b1;
          thr_d  = '0;
          pit_d  = '0;
          rol_d  = '0;
          yaw_d  = '0;
        end
      end else begin
        us_d = us_q + 1'b1;
      end
    end

    case (state_q)
      ST_HUNT, ST_SKIP: begin
        if (rise && is_sync) begin
          state_d = ST_CH;
          idx_d   = '0;
        end
      end
      ST_CH: begin
        if (rise) begin
          if (is_sync) begin
            idx_d = '0;
          end else if (is_chan) begin
            shadow_d[idx_q] = iv_q[RC_W_W-1:0];
            if (idx_q == 2'(RC_NUM_CH - 1)) state_d = ST_COMMIT;
            else idx_d = idx_q + 1'b1;
          end else begin
            state_d = ST_HUNT;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_SKIP;
        thr_d   = rc_throttle(shadow_q[RC_CH_THROTTLE]);
        rol_d   = axis_offset(shadow_q[RC_CH_ROLL]);
        pit_d   = axis_offset(shadow_q[RC_CH_PITCH]);
        yaw_d   = axis_offset(shadow_q[RC_CH_YAW]);
        fv_d    = 1'b1;
        lost_d  = 1'b0;
        us_d    = '0;
        ms_d    = '0;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ppm_s1_q <= 1'b0;
      ppm_s2_q <= 1'b0;
      ppm_s3_q <= 1'b0;
      state_q  <= ST_HUNT;
      idx_q    <= '0;
      iv_q     <= '0;
      us_q     <= '0;
      ms_q     <= MS_W'(FAILSAFE_MS);
      thr_q    <= '0;
      pit_q    <= '0;
      rol_q    <= '0;
      yaw_q    <= '0;
      fv_q     <= 1'b0;
      lost_q   <= 1'b1;
      for (int i = 0; i < RC_NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      ppm_s1_q <= ppm_in;
      ppm_s2_q <= ppm_s1_q;
      ppm_s3_q <= ppm_s2_q;
      state_q  <= state_d;
      idx_q    <= idx_d;
      iv_q     <= iv_d;
      us_q     <= us_d;
      ms_q     <= ms_d;
      thr_q    <= thr_d;
      pit_q    <= pit_d;
      rol_q    <= rol_d;
      yaw_q    <= yaw_d;
      fv_q     <= fv_d;
      lost_q   <= lost_d;
      shadow_q <= shadow_d;
    end
  end

  assign throttle_offset = thr_q;
  assign pitch_offset    = pit_q;
  assign roll_offset     = rol_q;
  assign yaw_offset      = yaw_q;
  assign frame_valid     = fv_q;
  assign signal_lost     = lost_q;

endmodule

// File: tb/tb_rc_ppm_decoder.sv
// tb/tb_rc_ppm_decoder.sv - scoreboard bench for rc_ppm_decoder with a list-based frame model
module tb_rc_ppm_decoder;

  localparam int FS_MS = 6;
  localparam int H     = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        ppm_in;
  logic [10:0] thr, pit, rol, yaw;
  logic        fv, lost;

  rc_ppm_decoder #(.CLK_HZ(1_000_000), .FAILSAFE_MS(FS_MS)) dut (
    .clk            (clk),
    .rst            (rst),
    .ppm_in         (ppm_in),
    .throttle_offset(thr),
    .pitch_offset   (pit),
    .roll_offset    (rol),
    .yaw_offset     (yaw),
    .frame_valid    (fv),
    .signal_lost    (lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int thr;
    int rol;
    int pit;
    int yaw;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_pass = 0;
  int   n_total = 0;
  int   col = -1;
  int   vals[4];
  int   last_rise = 0;

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int axis(int w);
    int d;
    d = w - 1500;
`ifdef RC_PPM_DEADBAND_EN
    if (d >= -20 && d <= 20) return 0;
`endif
    return clampi(d, -500, 500);
  endfunction

  // A rising edge closes the interval since the previous one; a sync starts
  // collecting, four good channels make a frame, anything else abandons it.
  task automatic model_rise();
    int   iv;
    exp_t e;
    iv = cyc - last_rise;
    last_rise = cyc;
    if (iv > 8191) iv = 8191;
    if (iv >= 3000) begin
      col = 0;
    end else if (col >= 0) begin
      if (iv >= 900 && iv <= 2100) begin
        vals[col] = iv;
        col++;
        if (col == 4) begin
          e.thr = clampi(vals[0] - 1000, 0, 1000);
          e.rol = axis(vals[1]);
          e.pit = axis(vals[2]);
          e.yaw = axis(vals[3]);
          e.at  = cyc + 4;
          sb.push_back(e);
          last = e;
          col = -1;
        end
      end else begin
        col = -1;
      end
    end
  endtask

  task automatic rise_edge();
    ppm_in = 1'b1;
    model_rise();
    repeat (H) @(negedge clk);
    ppm_in = 1'b0;
  endtask

  task automatic send(int len);
    rise_edge();
    repeat (len - H) @(negedge clk);
  endtask

  task automatic frame(int sync, int c0, int c1, int c2, int c3);
    send(sync);
    send(c0);
    send(c1);
    send(c2);
    send(c3);
  endtask

  task automatic check_outputs(string tag, int t, int r, int p, int y);
    check({tag, "_throttle"}, int'(thr), t);
    check({tag, "_roll"}, int'($signed(rol)), r);
    check({tag, "_pitch"}, int'($signed(pit)), p);
    check({tag, "_yaw"}, int'($signed(yaw)), y);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && fv) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL spurious_frame_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("commit_latency", cyc, e.at);
        check_outputs("commit", e.thr, e.rol, e.pit, e.yaw);
        check("commit_signal_lost", int'(lost), 0);
      end
    end else if (sb.size() > 0 && cyc > sb[0].at) begin
      n_total++;
      $display("FAIL missing_frame_valid: got 0 expected 1 at cycle %0d", sb[0].at);
      void'(sb.pop_front());
    end
  end

  initial begin
    int tc;
    rst    = 1'b1;
    ppm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 0, 0, 0);
    check("reset_frame_valid", int'(fv), 0);
    check("reset_signal_lost", int'(lost), 1);
    rst = 1'b0;
    last_rise = cyc;

    frame(3000, 1000, 1500, 1500, 1500);
    frame(3000, 2000, 1000, 2100, 900);

    // Asynchronous reset in the middle of a frame.
    send(3000);
    send(1300);
    #2 rst = 1'b1;
    #1;
    check_outputs("async_reset", 0, 0, 0, 0);
    check("async_reset_frame_valid", int'(fv), 0);
    check("async_reset_signal_lost", int'(lost), 1);
    col = -1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_rise = cyc;

    // Channels without a fresh sync must not commit.
    send(1000);
    send(1000);
    frame(3000, 1200, 1100, 1300, 1000);

    // Bad pulse: 850 us aborts the frame and outputs hold.
    send(3000);
    send(1500);
    send(850);
    rise_edge();
    check_outputs("bad_pulse_hold", last.thr, last.rol, last.pit, last.yaw);
    repeat (3000 - H) @(negedge clk);

    // Early sync restarts the frame.
    send(1200);
    send(1300);
    frame(3000, 1000, 1250, 1750, 1980);

    frame(3000 + $urandom_range(0, 300), $urandom_range(900, 2100), $urandom_range(900, 2100),
          $urandom_range(900, 2100), $urandom_range(900, 2100));

    // Failsafe: input held low after the last good frame.
    tc = cyc;
    rise_edge();
    repeat (4 + FS_MS * 1000 - 10 - H) @(negedge clk);
    check("failsafe_before", int'(lost), 0);
    repeat (20) @(negedge clk);
    check("failsafe_after", int'(lost), 1);
    check_outputs("failsafe", 0, 0, 0, 0);
    repeat (86) @(negedge clk);
    check("failsafe_elapsed", cyc - tc, 4 + FS_MS * 1000 + 96);

    // Eight-channel frame: ch4-7 ignored.
    frame(3000, 1500, 1525, 1515, 1480);
    for (int i = 0; i < 4; i++) send($urandom_range(500, 1200));
    rise_edge();
    check_outputs("extra_channels_ignored", last.thr, last.rol, last.pit, last.yaw);
    check("recovered_signal_lost", int'(lost), 0);
    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
